// File: rtl/immediate_genie.sv
// ============================================================================
// Module   : immediate_genie
// Purpose  : Decode-stage immediate generator with combinational and
//            one-cycle registered immediate / si shift-selector outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module immediate_genie (
   input  logic        In_Clk,
   input  logic        In_Reset_n,
   input  logic [15:0] In_Inst,
   output logic [15:0] Out_Imm,
   output logic [1:0]  Out_Si,
   output logic [15:0] Out_Imm_R,
   output logic [1:0]  Out_Si_R,
   output logic        Out_Illegal
);

   localparam logic [3:0] c_op_add  = 4'b0000;
   localparam logic [3:0] c_op_addi = 4'b0100;
   localparam logic [3:0] c_op_si   = 4'b0101;
   localparam logic [3:0] c_op_lw   = 4'b0111;
   localparam logic [3:0] c_op_sw   = 4'b1000;
   localparam logic [3:0] c_op_beq  = 4'b1001;
   localparam logic [3:0] c_op_jal  = 4'b1100;
   localparam logic [3:0] c_op_lui  = 4'b1110;
   localparam logic [3:0] c_op_lbi  = 4'b1111;

   logic [3:0]  w_opcode;
   logic [3:0]  w_a4;
   logic [7:0]  w_a8;
   logic [15:0] w_imm;
   logic [1:0]  w_si;
   logic        w_illegal;
   logic [15:0] r_imm;
   logic [1:0]  r_si;
   logic        w_unused;

   assign w_opcode = In_Inst[3:0];
   assign w_a4     = In_Inst[7:4];
   assign w_a8     = In_Inst[11:4];
   // Upper nibble is never part of any immediate field.
   assign w_unused = &{1'b0, In_Inst[15:12]};

   always_comb begin
      w_imm     = 16'h0000;
      w_illegal = 1'b0;
      case (w_opcode)
         c_op_add:                     w_imm = 16'h0000;
         c_op_addi, c_op_lw, c_op_sw:  w_imm = {{12{w_a4[3]}}, w_a4};
         c_op_si:                      w_imm = {12'h000, w_a4};
         c_op_beq, c_op_jal:           w_imm = {{8{w_a8[7]}}, w_a8};
         c_op_lui:                     w_imm = {w_a8, 8'h00};
         c_op_lbi:                     w_imm = {8'h00, w_a8};
         default:                      w_illegal = 1'b1;
      endcase
   end

   assign w_si = (w_opcode == c_op_si) ? In_Inst[9:8] : 2'b00;

   always_ff @(posedge In_Clk or negedge In_Reset_n) begin
      if (!In_Reset_n) begin
         r_imm <= 16'h0000;
         r_si  <= 2'b00;
      end else begin
         r_imm <= w_imm;
         r_si  <= w_si;
      end
   end

   assign Out_Imm     = w_imm;
   assign Out_Si      = w_si;
   assign Out_Illegal = w_illegal;
   assign Out_Imm_R   = r_imm;
   assign Out_Si_R    = r_si;

endmodule

`default_nettype wire

// File: tb/tb_immediate_genie.sv
// ============================================================================
// Module   : tb_immediate_genie
// Purpose  : Directed and random checks of immediate_genie against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_immediate_genie;

   logic        clk;
   logic        rst_n;
   logic [15:0] inst;
   logic [15:0] imm, imm_r;
   logic [1:0]  si, si_r;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   immediate_genie dut (
      .In_Clk      (clk),
      .In_Reset_n  (rst_n),
      .In_Inst     (inst),
      .Out_Imm     (imm),
      .Out_Si      (si),
      .Out_Imm_R   (imm_r),
      .Out_Si_R    (si_r),
      .Out_Illegal (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: value computed as a signed integer from the opcode rules.
   function automatic void model(input logic [15:0] in, output logic [15:0] m_imm,
                                 output logic [1:0] m_si, output logic m_ill);
      int a4, a8, v;
      a4    = int'(in[7:4]);
      a8    = int'(in[11:4]);
      v     = 0;
      m_ill = 1'b0;
      m_si  = 2'b00;
      case (in[3:0])
         4'd0:             v = 0;
         4'd4, 4'd7, 4'd8: v = (a4 >= 8) ? a4 - 16 : a4;
         4'd5: begin
            v    = a4;
            m_si = in[9:8];
         end
         4'd9, 4'd12:      v = (a8 >= 128) ? a8 - 256 : a8;
         4'd14:            v = a8 * 256;
         4'd15:            v = a8;
         default:          m_ill = 1'b1;
      endcase
      m_imm = v[15:0];
   endfunction

   logic [15:0] dir_inst [18];
   logic [15:0] dir_imm  [18];
   logic [1:0]  dir_si   [18];
   logic        dir_ill  [18];

   initial begin
      logic [15:0] e_imm, p_imm;
      logic [1:0]  e_si, p_si;
      logic        e_ill;

      dir_inst = '{16'h0120, 16'h0134, 16'h23F4, 16'h2147, 16'h32A7, 16'h1928,
                   16'h96E8, 16'h1207, 16'h8089, 16'h9FC9, 16'h206C, 16'hBF6C,
                   16'hD0DE, 16'h0EBE, 16'hC4AF, 16'hDAEF, 16'h21F5, 16'h0355};
      dir_imm  = '{16'h0000, 16'h0003, 16'hFFFF, 16'h0004, 16'hFFFA, 16'h0002,
                   16'hFFFE, 16'h0000, 16'h0008, 16'hFFFC, 16'h0006, 16'hFFF6,
                   16'h0D00, 16'hEB00, 16'h004A, 16'h00AE, 16'h000F, 16'h0005};
      dir_si   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                   2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3};
      dir_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      inst  = 16'hD0DE;
      #3;
      chk("reset_imm_r", imm_r, 16'h0000);
      chk("reset_si_r", {14'd0, si_r}, 16'h0000);
      chk("reset_comb_imm", imm, 16'h0D00);

      @(negedge clk);
      rst_n = 1'b1;

      // Directed plan vectors, combinational path.
      for (int i = 0; i < 18; i++) begin
         inst = dir_inst[i];
         #1;
         chk($sformatf("dir_imm_%h", dir_inst[i]), imm, dir_imm[i]);
         chk($sformatf("dir_si_%h", dir_inst[i]), {14'd0, si}, {14'd0, dir_si[i]});
         chk($sformatf("dir_ill_%h", dir_inst[i]), {15'd0, illegal}, {15'd0, dir_ill[i]});
      end

      // Extension boundaries and an illegal opcode.
      inst = 16'h0084; #1; chk("addi_min", imm, 16'hFFF8);
      inst = 16'hF078; #1; chk("sw_max", imm, 16'h0007);
      inst = 16'h0809; #1; chk("beq_min", imm, 16'hFF80);
      inst = 16'h080C; #1; chk("jal_min", imm, 16'hFF80);
      inst = 16'h080F; #1; chk("lbi_80", imm, 16'h0080);
      inst = 16'h0FFE; #1; chk("lui_ff", imm, 16'hFF00);
      inst = 16'h1232; #1;
      chk("ill_imm", imm, 16'h0000);
      chk("ill_flag", {15'd0, illegal}, 16'h0001);

      // Registered path with asynchronous reset.
      @(negedge clk); inst = 16'hD0DE;
      @(posedge clk); #1;
      chk("reg_lui", imm_r, 16'h0D00);
      @(negedge clk); inst = 16'h0355;
      @(posedge clk); #1;
      chk("reg_si_imm", imm_r, 16'h0005);
      chk("reg_si_sel", {14'd0, si_r}, 16'h0003);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_imm", imm_r, 16'h0000);
      chk("async_rst_si", {14'd0, si_r}, 16'h0000);
      chk("rst_comb_si", {14'd0, si}, 16'h0003);
      @(posedge clk); #1;
      chk("rst_hold_imm", imm_r, 16'h0000);
      @(negedge clk); rst_n = 1'b1; inst = 16'hD0DE;
      @(posedge clk); #1;
      chk("rst_release", imm_r, 16'h0D00);

      // Random instructions against the model, comb then registered.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         inst = 16'($urandom);
         #1;
         model(inst, e_imm, e_si, e_ill);
         chk($sformatf("rnd_imm_%h", inst), imm, e_imm);
         chk($sformatf("rnd_si_%h", inst), {14'd0, si}, {14'd0, e_si});
         chk($sformatf("rnd_ill_%h", inst), {15'd0, illegal}, {15'd0, e_ill});
         p_imm = e_imm;
         p_si  = e_si;
         @(posedge clk); #1;
         chk("rnd_imm_r", imm_r, p_imm);
         chk("rnd_si_r", {14'd0, si_r}, {14'd0, p_si});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
